ps2_rx: RTL
===========

# ps2_rx

PS/2 keyboard receiver that deserialises scancode frames from the keyboard's open-collector clock/data lines and issues a one-cycle write request carrying the decoded key event. It sits directly upstream of `ps2_vga_mux`. Its `mux_sel` output drives that mux, so for one cycle the mux takes the shared memory port away from VGA, asserts We and forces the keyboard mailbox address 10'h3FF. During that cycle `wr_data` is written into memory.

## Interface
- `TIMEOUT_CYCLES`, default 10000: number of `clk` cycles without a PS/2 falling edge, mid-frame, that aborts the frame (200 µs at 50 MHz).
- `SYNC_STAGES`, default 2: synchroniser depth on `ps2_clk` and `ps2_data`.

- `clk`  in  1: system clock; the only clock in the block.
- `reset`  in  1: synchronous, active-high reset.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous to `clk`, idles high.
- `ps2_data`  in  1: raw PS/2 data, asynchronous to `clk`, idles high.
- `mux_sel`  out  1: write request to `ps2_vga_mux`; high for exactly one cycle per key event.
- `wr_data`  out  16: key event word: [7:0] scancode, [8] break (release), [9] extended, [15:10] zero.
- `frame_err`  out  1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both PS/2 lines pass through SYNC_STAGES flops reset to 1. A further register on the synchronised clock feeds falling-edge detection (prev=1, cur=0). Data is sampled only on a detected falling edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data=0 → DATA with bit_cnt=0. Data=1 → `frame_err` pulse, stay IDLE.
  - DATA: on an edge, shift the data bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: on an edge, latch the parity bit → STOP.
  - STOP: on an edge, the frame is valid if stop=1 and odd parity holds (XOR of the 8 data bits and the parity bit = 1). Always → IDLE.
- Handling of a valid byte:
  - 8'hE0: set the `ext` flag; no write.
  - 8'hF0: set the `brk` flag; no write.
  - Any other byte: register `wr_data={6'b0,ext,brk,code}`, pulse `mux_sel`, then clear both flags.
- Invalid frame: `frame_err` pulse, no write, both prefix flags cleared.
- Timeout:
  - The idle counter resets on every falling edge and while in IDLE.
  - In a non-IDLE state, when the counter reaches TIMEOUT_CYCLES-1: → IDLE, `frame_err` pulse, flags cleared, no write.
  - If an edge and a timeout fall in the same cycle, the edge wins.
- `wr_data` holds its value from the write cycle until the next write. Only `mux_sel` marks the data as valid.
- Reset (including mid-frame) outputs: `mux_sel`=0, `wr_data`=16'h0000, `frame_err`=0. State → IDLE, bit_cnt=0, flags=0, synchronisers=1. A partial frame is discarded with no write and no error.

## Timing
- Latency: a pin falling edge is detected SYNC_STAGES+1 cycles later (3 cycles at default).
- `mux_sel` and the new `wr_data` are registered and appear in the cycle after the STOP edge is detected. Both change in the same cycle.
- The downstream mux is combinational, so We and address 10'h3FF are valid in that same cycle. Memory captures `wr_data` on the following rising edge of `clk`.
- `frame_err` has the same one-cycle-after-detection timing as `mux_sel`. The two are never high together.
- There is at most one `mux_sel` pulse per 11-bit frame. There is no backpressure: the memory port must accept the write in that cycle.

## Structure
- Package `ps2_pkg`:
  - state enum: IDLE, DATA, PARITY, STOP.
  - `PS2_EXT_CODE`=8'hE0, `PS2_BRK_CODE`=8'hF0.
  - `PS2_WR_ADDR`=10'h3FF, shared with `ps2_vga_mux`.
- Sub-module `ps2_sync_edge`: SYNC_STAGES synchroniser for both lines plus the falling-edge detector. Outputs: `fall` (1-cycle pulse) and `data_s` (synchronised data).

## Test plan
PS/2 clock period 20 cycles, TIMEOUT_CYCLES=100.

- Frame 8'h1C, parity 0, stop 1 → exactly one `mux_sel` pulse with `wr_data`=16'h001C; `frame_err` stays 0.
- Frames E0 (parity 0) then 75 (parity 0) → no write after E0; one write of 16'h0275.
- Frames F0 (parity 1) then 1C (parity 0) → one write of 16'h011C; the next bare 1C frame writes 16'h001C (flags cleared).
- Frame 8'h1C with parity 1 → `frame_err` pulse, no `mux_sel`. The following good 1C frame → write 16'h001C.
- Stop clocking after 5 data bits for 120 cycles → `frame_err` pulse, FSM in IDLE. The next full 8'h29 frame → write 16'h0029.
- `reset` for 1 cycle after the 4th data bit → all outputs 0, no write, no error. The next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, scancode prefixes and the
// keyboard mailbox address used by ps2_vga_mux.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
   localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
   localparam logic [9:0] PS2_WR_ADDR  = 10'h3FF;

   // Key event word: {zero pad, extended, break, scancode}
   function automatic logic [15:0] ps2_event_word(input logic ext, input logic brk,
                                                  input logic [7:0] code);
      return {6'b0, ext, brk, code};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines into the clk domain and
// flags falling edges of the synchronised PS/2 clock.
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_ps2_clk,
   input  logic i_ps2_data,
   output logic o_fall,
   output logic o_data_s
);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;

   // Both lines idle high, so resetting to 1 never fakes an edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync[0]  <= i_ps2_clk;
         r_data_sync[0] <= i_ps2_data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_clk_sync[i]  <= r_clk_sync[i-1];
            r_data_sync[i] <= r_data_sync[i-1];
         end
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign o_fall   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign o_data_s = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, folds E0/F0 prefixes
// into flags and issues a one-cycle write request carrying the key event.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ps2_clk,
   input  logic        i_ps2_data,
   output logic        o_mux_sel,
   output logic [15:0] o_wr_data,
   output logic        o_frame_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic w_fall;
   logic w_data_s;
   logic w_timeout;
   logic w_frame_ok;

   ps2_state_t       r_state;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic             r_ext;
   logic             r_brk;
   logic [CNT_W-1:0] r_cnt;

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_ps2_clk  (i_ps2_clk),
      .i_ps2_data (i_ps2_data),
      .o_fall     (w_fall),
      .o_data_s   (w_data_s)
   );

   // A stalled keyboard mid-frame must not wedge the receiver.
   assign w_timeout  = (r_state != ST_IDLE) && (r_cnt == TO_LAST);
   assign w_frame_ok = w_data_s && (^{r_shift, r_parity});

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_parity    <= 1'b0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_cnt       <= '0;
         o_mux_sel   <= 1'b0;
         o_wr_data   <= 16'h0000;
         o_frame_err <= 1'b0;
      end else begin
         o_mux_sel   <= 1'b0;
         o_frame_err <= 1'b0;

         if (r_state == ST_IDLE || w_fall) r_cnt <= '0;
         else                              r_cnt <= r_cnt + 1'b1;

         if (w_fall) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (!w_data_s) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= 3'd0;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {w_data_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= w_data_s;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (!w_frame_ok) begin
                     o_frame_err <= 1'b1;
                     r_ext       <= 1'b0;
                     r_brk       <= 1'b0;
                  end else if (r_shift == PS2_EXT_CODE) begin
                     r_ext <= 1'b1;
                  end else if (r_shift == PS2_BRK_CODE) begin
                     r_brk <= 1'b1;
                  end else begin
                     o_wr_data <= ps2_event_word(r_ext, r_brk, r_shift);
                     o_mux_sel <= 1'b1;
                     r_ext     <= 1'b0;
                     r_brk     <= 1'b0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            o_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
         end
      end
   end

endmodule
